pifo_rank_tagger: RTL and testbench



---
 rtl/pifo_rank_tagger.sv | 234 +++++++++++++++++++++++
 tb/tb_pifo_rank_tagger.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_rank_tagger.sv
// -----------------------------------------------------------------------------
// pifo_rank_tagger
//
// Purpose:
//   AXI4-Stream register slice placed in front of the PIFO enqueue agent. At the
//   start of every packet it computes a Start-Time Fair Queueing rank from a
//   per-flow finish-time table and a virtual-time register. It then writes that
//   rank into the tuser rank field of every beat of the packet. The virtual time
//   follows the rank of each packet dequeued from the PIFO.
//
// Configuration macro:
//   PIFO_RANK_FIFO_MODE_EN - when defined, the rank is a wrapping arrival counter
//                            that advances on each start-of-packet. In this mode
//                            the flow table and the virtual time are absent, and
//                            deq_valid/deq_rank are ignored. Ranks therefore follow
//                            arrival order, so the PIFO behaves as a FIFO.
//                            When undefined, the STFQ rank is produced.
//
// Ports:
//   clk_in_0        in   sole clock
//   resetn          in   asynchronous, active-low reset
//   s_axis_tdata    in   ingress data             [DATA_WIDTH-1:0]
//   s_axis_tkeep    in   ingress byte enables     [DATA_WIDTH/8-1:0]
//   s_axis_tuser    in   ingress metadata         [SUME_META_WIDTH-1:0]
//                        (length in [15:0], flow id at FLOW_ID_LSB)
//   s_axis_tvalid   in   ingress valid
//   s_axis_tlast    in   ingress end of packet
//   s_axis_tready   out  ingress ready (combinational)
//   m_axis_tdata    out  egress data
//   m_axis_tkeep    out  egress byte enables
//   m_axis_tuser    out  egress metadata, rank field at RANK_LSB replaced
//   m_axis_tvalid   out  egress valid
//   m_axis_tlast    out  egress end of packet
//   m_axis_tready   in   egress ready
//   deq_valid       in   a packet left the PIFO this cycle
//   deq_rank        in   rank of the dequeued packet [RANK_WIDTH-1:0]
// -----------------------------------------------------------------------------
module pifo_rank_tagger #(
  parameter int DATA_WIDTH      = 256,
  parameter int SUME_META_WIDTH = 128,
  parameter int FLOW_ID_WIDTH   = 4,
  parameter int FLOW_ID_LSB     = 64,
  parameter int RANK_WIDTH      = 16,
  parameter int RANK_LSB        = 96
) (
  input  logic                         clk_in_0,
  input  logic                         resetn,

  input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]      s_axis_tkeep,
  input  logic [SUME_META_WIDTH-1:0]   s_axis_tuser,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,

  output logic [DATA_WIDTH-1:0]        m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]      m_axis_tkeep,
  output logic [SUME_META_WIDTH-1:0]   m_axis_tuser,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,

  input  logic                         deq_valid,
  input  logic [RANK_WIDTH-1:0]        deq_rank
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;

  // ---------------------------------------------------------------------------
  // Handshake and framing
  // ---------------------------------------------------------------------------
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  state_t                      state_reg;
  logic                        accept;
  logic                        sop;

  logic                        tvalid_reg;
  logic [DATA_WIDTH-1:0]       tdata_reg;
  logic [KEEP_WIDTH-1:0]       tkeep_reg;
  logic [SUME_META_WIDTH-1:0]  tuser_reg;
  logic                        tlast_reg;

  logic [RANK_WIDTH-1:0]       sop_rank;   // rank computed for the beat on the input now
  logic [RANK_WIDTH-1:0]       rank_reg;   // rank latched at the last start-of-packet
  logic [RANK_WIDTH-1:0]       beat_rank;
  logic [SUME_META_WIDTH-1:0]  tagged_user;

  // The slice can take a new beat when it is empty or when its current beat
  // leaves on this same edge.
  assign s_axis_tready = !tvalid_reg || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  // Any beat accepted in IDLE opens a packet, including single-beat packets.
  assign sop           = accept && (state_reg == ST_IDLE);

  always_ff @(posedge clk_in_0 or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
    end else if (accept) begin
      state_reg <= s_axis_tlast ? ST_IDLE : ST_IN_PKT;
    end
  end

  // ---------------------------------------------------------------------------
  // Rank source
  // ---------------------------------------------------------------------------
`ifdef PIFO_RANK_FIFO_MODE_EN

  // Arrival order: each new packet gets the next counter value.
  logic [RANK_WIDTH-1:0] arrival_cnt_reg;
  logic                  unused_deq;

  assign sop_rank   = arrival_cnt_reg;
  // Dequeue feedback has no effect in arrival-order mode.
  assign unused_deq = deq_valid ^ (^deq_rank);

  always_ff @(posedge clk_in_0 or negedge resetn) begin
    if (!resetn) begin
      arrival_cnt_reg <= '0;
    end else if (sop) begin
      arrival_cnt_reg <= arrival_cnt_reg + RANK_WIDTH'(1);
    end
  end

`else

  localparam int NUM_FLOWS = 1 << FLOW_ID_WIDTH;

  // Finish times live in flip-flops: the start time is needed in the same
  // cycle that the SOP beat is presented, so a registered-read RAM would not work.
  logic [RANK_WIDTH-1:0]       flow_table_reg [NUM_FLOWS];
  logic [RANK_WIDTH-1:0]       vtime_reg;

  logic [FLOW_ID_WIDTH-1:0]    flow_id;
  logic [RANK_WIDTH-1:0]       pkt_len;
  logic [RANK_WIDTH-1:0]       flow_finish;
  logic [RANK_WIDTH-1:0]       finish_ahead;
  logic                        finish_wins;
  logic [RANK_WIDTH-1:0]       finish_next;
  logic [NUM_FLOWS-1:0]        flow_we;

  assign flow_id     = s_axis_tuser[FLOW_ID_LSB +: FLOW_ID_WIDTH];
  assign pkt_len     = RANK_WIDTH'(s_axis_tuser[15:0]);
  assign flow_finish = flow_table_reg[flow_id];

  // Wrap-aware max(V, F): F is "later" only when the modular distance F - V
  // is strictly positive as a signed value. This keeps ordering correct
  // across a rank wrap, provided live ranks stay within half the rank space.
  assign finish_ahead = flow_finish - vtime_reg;
  assign finish_wins  = !finish_ahead[RANK_WIDTH-1] && (finish_ahead != '0);
  assign sop_rank     = finish_wins ? flow_finish : vtime_reg;
  assign finish_next  = sop_rank + pkt_len;

  // Only the entry of the SOP's flow is written. Beats inside a packet never
  // decode tuser.
  generate
    for (genvar gi = 0; gi < NUM_FLOWS; gi++) begin : g_flow_we
      assign flow_we[gi] = sop && (flow_id == FLOW_ID_WIDTH'(gi));
    end
  endgenerate

  always_ff @(posedge clk_in_0 or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        flow_table_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FLOWS; i++) begin
        if (flow_we[i]) begin
          flow_table_reg[i] <= finish_next;
        end
      end
    end
  end

  // When SOP and dequeue coincide, the SOP above already used the old V.
  always_ff @(posedge clk_in_0 or negedge resetn) begin
    if (!resetn) begin
      vtime_reg <= '0;
    end else if (deq_valid) begin
      vtime_reg <= deq_rank;
    end
  end

`endif

  // ---------------------------------------------------------------------------
  // Rank insertion and output register
  // ---------------------------------------------------------------------------
  assign beat_rank = sop ? sop_rank : rank_reg;

  always_comb begin
    tagged_user                            = s_axis_tuser;
    tagged_user[RANK_LSB +: RANK_WIDTH]    = beat_rank;
  end

  always_ff @(posedge clk_in_0 or negedge resetn) begin
    if (!resetn) begin
      rank_reg <= '0;
    end else if (sop) begin
      rank_reg <= sop_rank;
    end
  end

  // The output registers load only on acceptance, so a stalled beat holds
  // steady until the downstream stage takes it.
  always_ff @(posedge clk_in_0 or negedge resetn) begin
    if (!resetn) begin
      tvalid_reg <= 1'b0;
      tdata_reg  <= '0;
      tkeep_reg  <= '0;
      tuser_reg  <= '0;
      tlast_reg  <= 1'b0;
    end else if (accept) begin
      tvalid_reg <= 1'b1;
      tdata_reg  <= s_axis_tdata;
      tkeep_reg  <= s_axis_tkeep;
      tuser_reg  <= tagged_user;
      tlast_reg  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      tvalid_reg <= 1'b0;
    end
  end

  assign m_axis_tvalid = tvalid_reg;
  assign m_axis_tdata  = tdata_reg;
  assign m_axis_tkeep  = tkeep_reg;
  assign m_axis_tuser  = tuser_reg;
  assign m_axis_tlast  = tlast_reg;

endmodule

// File: tb/tb_pifo_rank_tagger.sv
// -----------------------------------------------------------------------------
// tb_pifo_rank_tagger
//
// Purpose:
//   Self-checking bench for pifo_rank_tagger. A packet-level reference model
//   keeps finish times, virtual time and an arrival counter as plain integers.
//   It queues every accepted beat with its expected rank, and each cycle the
//   DUT's output and ready are compared with that queue. It runs directed
//   scenarios, then randomized traffic with random backpressure and dequeue
//   feedback.
//   When PIFO_RANK_FIFO_MODE_EN is defined, the model switches to arrival order.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pifo_rank_tagger;

  localparam int          DW   = 256;
  localparam int          UW   = 128;
  localparam int          KW   = DW / 8;
  localparam int unsigned RMOD = 65536;

  logic           clk_in_0 = 1'b0;
  logic           resetn   = 1'b0;
  logic [DW-1:0]  s_axis_tdata  = '0;
  logic [KW-1:0]  s_axis_tkeep  = '0;
  logic [UW-1:0]  s_axis_tuser  = '0;
  logic           s_axis_tvalid = 1'b0;
  logic           s_axis_tlast  = 1'b0;
  logic           s_axis_tready;
  logic [DW-1:0]  m_axis_tdata;
  logic [KW-1:0]  m_axis_tkeep;
  logic [UW-1:0]  m_axis_tuser;
  logic           m_axis_tvalid;
  logic           m_axis_tlast;
  logic           m_axis_tready = 1'b1;
  logic           deq_valid     = 1'b0;
  logic [15:0]    deq_rank      = '0;

  pifo_rank_tagger dut (
    .clk_in_0      (clk_in_0),
    .resetn        (resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .deq_valid     (deq_valid),
    .deq_rank      (deq_rank)
  );

  always #5 clk_in_0 = ~clk_in_0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic [UW-1:0] user;
    logic          last;
    logic          sop;
  } beat_t;

  // Reference model state
  beat_t       sb[$];          // beats expected on the egress, oldest first
  int unsigned fin[16];        // per-flow finish time
  int unsigned vt;             // virtual time
  int unsigned arrivals;       // arrival counter for FIFO mode
  int unsigned cur_rank;       // rank of the packet currently being accepted
  bit          in_pkt;
  int unsigned rank_log[$];    // observed ranks of emitted SOP beats

  // Stimulus controls
  bit          rand_en  = 1'b0;
  int          hold_cnt = 0;
  bit          deq_pend = 1'b0;
  logic [15:0] deq_pend_rank = '0;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Later of two ranks on the 16-bit circle: b wins when it lies strictly
  // ahead of a by less than half the circle.
  function automatic int unsigned wmax(input int unsigned a, input int unsigned b);
    int unsigned d;
    d = (b + RMOD - a) % RMOD;
    return (d != 0 && d < RMOD / 2) ? b : a;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [UW-1:0] rand_user();
    logic [UW-1:0] u;
    for (int i = 0; i < UW / 32; i++) u[i*32 +: 32] = $urandom;
    return u;
  endfunction

  // One clock cycle: drive inputs at the falling edge, check the DUT against
  // the model, then advance the model for the coming rising edge.
  task automatic cycle(input logic v, input beat_t b, output bit acc);
    logic        rdy;
    logic        dv;
    logic [15:0] dr;
    bit          exp_rdy;
    int          f;
    beat_t       e;
    @(negedge clk_in_0);
    rdy = 1'b1;
    dv  = 1'b0;
    dr  = '0;
    if (hold_cnt > 0) begin
      rdy = 1'b0;
      hold_cnt--;
    end else if (rand_en) begin
      rdy = ($urandom_range(3) != 0);
    end
    if (rand_en) begin
      dv = ($urandom_range(7) == 0);
      dr = 16'($urandom);
    end
    if (deq_pend) begin
      dv = 1'b1;
      dr = deq_pend_rank;
      deq_pend = 1'b0;
    end
    s_axis_tvalid = v;
    s_axis_tdata  = b.data;
    s_axis_tkeep  = b.keep;
    s_axis_tuser  = b.user;
    s_axis_tlast  = b.last;
    m_axis_tready = rdy;
    deq_valid     = dv;
    deq_rank      = dr;
    #1;
    exp_rdy = (sb.size() == 0) || rdy;
    check_eq("s_tready", s_axis_tready, exp_rdy);
    if (sb.size() != 0) begin
      check_eq("m_tvalid", m_axis_tvalid, 1'b1);
      check_eq("m_tdata", m_axis_tdata, sb[0].data);
      check_eq("m_meta", {m_axis_tlast, m_axis_tkeep, m_axis_tuser},
               {sb[0].last, sb[0].keep, sb[0].user});
      if (rdy) begin
        if (sb[0].sop) rank_log.push_back(int'(m_axis_tuser[96 +: 16]));
        void'(sb.pop_front());
      end
    end else begin
      check_eq("m_tvalid_idle", m_axis_tvalid, 1'b0);
    end
    acc = v && exp_rdy;
    if (acc) begin
      e = b;
      if (!in_pkt) begin
`ifdef PIFO_RANK_FIFO_MODE_EN
        cur_rank = arrivals;
        arrivals = (arrivals + 1) % RMOD;
`else
        f        = int'(b.user[64 +: 4]);
        cur_rank = wmax(vt, fin[f]);
        fin[f]   = (cur_rank + int'(b.user[15:0])) % RMOD;
`endif
      end
      e.user[96 +: 16] = cur_rank[15:0];
      e.sop            = !in_pkt;
      sb.push_back(e);
      in_pkt = !b.last;
    end
`ifndef PIFO_RANK_FIFO_MODE_EN
    if (dv) vt = int'(dr);
`endif
  endtask

  task automatic idle(input int n);
    bit    acc;
    beat_t blank;
    blank = '0;
    for (int i = 0; i < n; i++) cycle(1'b0, blank, acc);
  endtask

  task automatic send_beat(input beat_t b);
    bit acc;
    int n;
    n = 0;
    do begin
      cycle(1'b1, b, acc);
      n++;
    end while (!acc && n < 40);
    if (!acc) check_eq("accept_timeout", acc, 1'b1);
  endtask

  task automatic send_pkt(input int flow, input int len, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.data = rand_data();
      b.keep = KW'({$urandom, $urandom});
      b.user = rand_user();
      if (i == 0) begin
        b.user[15:0]    = 16'(len);
        b.user[64 +: 4] = 4'(flow);
      end
      b.last = (i == nbeats - 1);
      b.sop  = 1'b0;
      send_beat(b);
      if (rand_en && $urandom_range(3) == 0) idle(1);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in_0);
    resetn        = 1'b0;
    s_axis_tvalid = 1'b0;
    deq_valid     = 1'b0;
    #1;
    check_eq("rst_tvalid", m_axis_tvalid, 1'b0);
    check_eq("rst_tdata", m_axis_tdata, 0);
    check_eq("rst_meta", {m_axis_tlast, m_axis_tkeep, m_axis_tuser}, 0);
    sb.delete();
    for (int i = 0; i < 16; i++) fin[i] = 0;
    vt       = 0;
    arrivals = 0;
    cur_rank = 0;
    in_pkt   = 1'b0;
    @(negedge clk_in_0);
    resetn = 1'b1;
  endtask

  // Compare the k-th rank emitted since the last rank_log.delete().
  task automatic check_rank(input string tag, input int k, input int unsigned exp);
    int unsigned got;
    got = (k < rank_log.size()) ? rank_log[k] : 32'hDEAD_BEEF;
    check_eq(tag, got, exp);
  endtask

  initial begin
    do_reset();

`ifndef PIFO_RANK_FIFO_MODE_EN
    // Single flow, two-beat packets
    rank_log.delete();
    send_pkt(3, 100, 2);
    send_pkt(3, 200, 2);
    send_pkt(3, 50, 2);
    idle(3);
    check_rank("single_r0", 0, 0);
    check_rank("single_r1", 1, 100);
    check_rank("single_r2", 2, 300);

    // Two flows interleaved, then virtual time jumps past flow 2
    do_reset();
    rank_log.delete();
    send_pkt(1, 500, 1);
    send_pkt(2, 100, 1);
    send_pkt(2, 100, 1);
    deq_pend = 1'b1; deq_pend_rank = 16'd400;
    idle(1);
    send_pkt(2, 10, 1);
    idle(3);
    check_rank("two_r0", 0, 0);
    check_rank("two_r1", 1, 0);
    check_rank("two_r2", 2, 100);
    check_rank("two_r3", 3, 400);

    // Backpressure on a four-beat packet
    hold_cnt = 6;
    send_pkt(7, 64, 4);
    idle(3);

    // Wrap-around of the rank space
    do_reset();
    rank_log.delete();
    send_pkt(0, 16'hFFF0, 1);
    deq_pend = 1'b1; deq_pend_rank = 16'hFFE0;
    idle(1);
    send_pkt(0, 16'h0020, 2);
    send_pkt(0, 1, 1);
    idle(3);
    check_rank("wrap_r0", 1, 32'hFFF0);
    check_rank("wrap_r1", 2, 32'h0010);

    // SOP and dequeue in the same cycle
    do_reset();
    rank_log.delete();
    send_pkt(5, 50, 1);
    idle(1);
    deq_pend = 1'b1; deq_pend_rank = 16'd80;
    send_pkt(5, 10, 1);
    send_pkt(5, 0, 1);
    idle(3);
    check_rank("simul_r0", 1, 50);
    check_rank("simul_r1", 2, 80);
`else
    // Arrival order regardless of flow, length or dequeue feedback
    rank_log.delete();
    deq_pend = 1'b1; deq_pend_rank = 16'd900;
    send_pkt(1, 50, 2);
    deq_pend = 1'b1; deq_pend_rank = 16'd5;
    send_pkt(7, 0, 1);
    send_pkt(12, 999, 3);
    idle(3);
    check_rank("fifo_r0", 0, 0);
    check_rank("fifo_r1", 1, 1);
    check_rank("fifo_r2", 2, 2);
`endif

    // Reset in the middle of a three-beat packet
    begin
      beat_t b;
      b.data = rand_data(); b.keep = '1; b.user = rand_user();
      b.user[15:0] = 16'd30; b.user[64 +: 4] = 4'd9; b.last = 1'b0; b.sop = 1'b0;
      send_beat(b);
      b.data = rand_data(); b.user = rand_user();
      send_beat(b);
    end
    do_reset();
    rank_log.delete();
    send_pkt(5, 7, 1);
    idle(2);
    check_rank("midrst_r0", 0, 0);

    // Randomized traffic with backpressure and dequeue feedback
    rand_en = 1'b1;
    for (int p = 0; p < 150; p++) begin
      int len;
      case ($urandom_range(3))
        0:       len = 0;
        1:       len = int'($urandom_range(255));
        default: len = int'($urandom_range(65535));
      endcase
      if ($urandom_range(15) == 0) hold_cnt = int'($urandom_range(6));
      send_pkt(int'($urandom_range(15)), len, int'($urandom_range(1, 4)));
      if ($urandom_range(3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rand_en = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
